if_stage_fetch_ctrl: RTL and testbench
======================================

Name: if_stage_fetch_ctrl

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; directly upstream of the ID-stage branch hazard/predict-not-taken handler.
- Owns the PC register and next-PC selection, the instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes the handler's branch_hazard_stall / branch_taken_IF_flush plus the load-use stall, and produces the instruction/PC+4 that ID decodes.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) loaded into IF/ID on flush/bubble
STATS_W, 16, width of statistics counters (BRANCH_STATS_EN only)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; 1 whenever not in reset
imem_addr  out  32  fetch address (= pc), held stable while imem_req & ~imem_ready
imem_rdata  in  32  instruction, valid when imem_ready=1
imem_ready  in  1  completes the outstanding fetch this cycle
load_use_stall  in  1  hazard unit load-use stall
branch_hazard_stall  in  1  ID branch operand-hazard stall
branch_taken_IF_flush  in  1  beq resolved taken in ID
branch_target  in  32  taken-branch target from ID
jump_en  in  1  ID decoded j/jal
jump_target  in  32  jump target from ID
if_pc  out  32  current PC
ifid_instr  out  32  IF/ID instruction
ifid_pc_plus4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, state=FETCH, redir_pend=0, redir_addr=0. imem_req=0 while rst_n=0.
- stall = load_use_stall | branch_hazard_stall.
- eff_flush = branch_taken_IF_flush & ~branch_hazard_stall (a flush is ignored while its operands are unresolved).
- redirect = eff_flush | jump_en; target = eff_flush ? branch_target : jump_target (branch wins when both are asserted).
- States: FETCH (request issued this cycle) and WAIT (previous cycle's request not yet complete). A cycle with imem_ready=0 moves or stays in WAIT; imem_ready=1 returns to FETCH.
- Completion cycle (imem_ready=1), priority:
  1. redirect: pc<=target; IF/ID<=NOP, valid 0; rdata dropped.
  2. redir_pend: pc<=redir_addr; IF/ID<=NOP, valid 0; clear redir_pend.
  3. stall: pc and IF/ID hold; rdata dropped (refetched next cycle).
  4. Otherwise: pc<=pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0); ifid_instr<=imem_rdata; ifid_pc_plus4<=pc+4; valid 1.
- Non-completion cycle (imem_ready=0):
  - pc holds; imem_addr stays stable.
  - redirect: redir_pend<=1, redir_addr<=target. A later redirect overwrites redir_addr.
  - IF/ID: on redirect, NOP/valid 0; else on stall, hold; else NOP/valid 0 (bubble).
- Latency: instruction reaches IF/ID on the posedge of its completion cycle. Zero-wait memory gives one instruction per cycle.
- Flush penalty: exactly one bubble (predict not-taken, branch resolved in ID).
- Reset mid-WAIT: outstanding fetch abandoned, redir_pend cleared; the memory must accept a new address on the next cycle.

Optional Feature:
- BRANCH_STATS_EN defined: adds outputs stat_fetches, stat_flushes, stat_stall_cycles (each STATS_W, saturating at all-ones, reset to 0).
  - stat_fetches counts case-4 completions.
  - stat_flushes counts eff_flush cycles.
  - stat_stall_cycles counts stall cycles.
- BRANCH_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, imem_ready=1 always, rdata = address -> ifid_pc_plus4 takes 4, 8, 12 on successive cycles; ifid_valid=1 from the first posedge after reset.
- At pc=0x10, branch_taken_IF_flush=1 with branch_target=0x40 -> next cycle if_pc=0x40, ifid_instr=NOP, ifid_valid=0; the following cycle ifid_pc_plus4=0x44.
- branch_taken_IF_flush=1 with branch_hazard_stall=1 -> pc and IF/ID hold and no redirect occurs; flush is taken only once the stall drops.
- imem_ready low for 3 cycles at pc=0x20, with jump_en=1 (target 0x80) during the 2nd wait cycle -> imem_addr held at 0x20; at completion rdata is dropped and pc becomes 0x80.
- load_use_stall=1 for 2 cycles -> if_pc and ifid_* unchanged for 2 cycles, then the sequence resumes without skipping an address.
- pc=0xFFFF_FFFC, no hazards -> next pc=0x0000_0000, ifid_pc_plus4=0x0000_0000. With BRANCH_STATS_EN, a 2-flush run gives stat_flushes=2.

Source files
------------

// File: rtl/if_stage_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// if_stage_fetch_ctrl_if
// Instruction-memory fetch handshake between the IF stage and the memory.
//   imem_req   : fetch request (IF -> mem)
//   imem_addr  : fetch address, stable while a request is outstanding (IF -> mem)
//   imem_rdata : returned instruction, valid when imem_ready=1 (mem -> IF)
//   imem_ready : completes the outstanding fetch this cycle (mem -> IF)
// Modports: master = fetch controller, slave = instruction memory.
// -----------------------------------------------------------------------------
interface if_stage_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_stage_fetch_ctrl
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// instruction-memory handshake and the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   imem                    : fetch handshake (master modport)
//   load_use_stall          : load-use stall from the hazard unit
//   branch_hazard_stall     : ID branch operand-hazard stall
//   branch_taken_IF_flush   : beq resolved taken in ID
//   branch_target           : taken-branch target
//   jump_en, jump_target    : j/jal decoded in ID and its target
//   if_pc                   : current PC
//   ifid_instr, ifid_pc_plus4, ifid_valid : IF/ID register
//   stat_fetches, stat_flushes, stat_stall_cycles : saturating statistics,
//                             present only when BRANCH_STATS_EN is defined
//
// Optional feature macro: BRANCH_STATS_EN
// -----------------------------------------------------------------------------
module if_stage_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          STATS_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef BRANCH_STATS_EN
  output logic [STATS_W-1:0]  stat_fetches,
  output logic [STATS_W-1:0]  stat_flushes,
  output logic [STATS_W-1:0]  stat_stall_cycles,
`endif
  if_stage_fetch_ctrl_if.master imem,
  input  logic                load_use_stall,
  input  logic                branch_hazard_stall,
  input  logic                branch_taken_IF_flush,
  input  logic [31:0]         branch_target,
  input  logic                jump_en,
  input  logic [31:0]         jump_target,
  output logic [31:0]         if_pc,
  output logic [31:0]         ifid_instr,
  output logic [31:0]         ifid_pc_plus4,
  output logic                ifid_valid
);

  typedef enum logic {FETCH, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic        redir_pend_reg, redir_pend_next;
  logic [31:0] redir_addr_reg, redir_addr_next;
  logic        fetch_accept;

  logic        stall;
  logic        eff_flush;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign stall     = load_use_stall | branch_hazard_stall;
  // A taken branch whose operands are still unresolved is not yet real.
  assign eff_flush = branch_taken_IF_flush & ~branch_hazard_stall;
  assign redirect  = eff_flush | jump_en;
  assign target    = eff_flush ? branch_target : jump_target;
  assign pc_plus4  = pc_reg + 32'd4;

  assign imem.imem_req  = rst_n;
  assign imem.imem_addr = pc_reg;
  assign if_pc          = pc_reg;
  assign ifid_instr     = instr_reg;
  assign ifid_pc_plus4  = pc4_reg;
  assign ifid_valid     = valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      pc4_reg        <= 32'd0;
      valid_reg      <= 1'b0;
      redir_pend_reg <= 1'b0;
      redir_addr_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      pc4_reg        <= pc4_next;
      valid_reg      <= valid_next;
      redir_pend_reg <= redir_pend_next;
      redir_addr_reg <= redir_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pc4_next        = pc4_reg;
    valid_next      = valid_reg;
    redir_pend_next = redir_pend_reg;
    redir_addr_next = redir_addr_reg;
    fetch_accept    = 1'b0;

    case (state_reg)
      FETCH:   if (!imem.imem_ready) state_next = WAIT;
      WAIT:    if (imem.imem_ready)  state_next = FETCH;
      default: state_next = FETCH;
    endcase

    if (imem.imem_ready) begin
      if (redirect) begin
        pc_next    = target;
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end else if (redir_pend_reg) begin
        // The data just returned belongs to the pre-redirect address.
        pc_next         = redir_addr_reg;
        instr_next      = NOP_INSTR;
        valid_next      = 1'b0;
        redir_pend_next = 1'b0;
      end else if (!stall) begin
        fetch_accept = 1'b1;
        pc_next      = pc_plus4;
        instr_next   = imem.imem_rdata;
        pc4_next     = pc_plus4;
        valid_next   = 1'b1;
      end
      // Stall on completion: hold everything, the same address is refetched.
    end else begin
      // Address must stay put until the memory completes, so a redirect is
      // remembered and applied on completion.
      if (redirect) begin
        redir_pend_next = 1'b1;
        redir_addr_next = target;
        instr_next      = NOP_INSTR;
        valid_next      = 1'b0;
      end else if (!stall) begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] fetches_reg, flushes_reg, stalls_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetches_reg <= '0;
      flushes_reg <= '0;
      stalls_reg  <= '0;
    end else begin
      if (fetch_accept && !(&fetches_reg)) fetches_reg <= fetches_reg + 1'b1;
      if (eff_flush && !(&flushes_reg))    flushes_reg <= flushes_reg + 1'b1;
      if (stall && !(&stalls_reg))         stalls_reg  <= stalls_reg + 1'b1;
    end
  end

  assign stat_fetches      = fetches_reg;
  assign stat_flushes      = flushes_reg;
  assign stat_stall_cycles = stalls_reg;
`else
  logic unused_fetch_accept;
  assign unused_fetch_accept = fetch_accept;
`endif

endmodule

// File: tb/tb_if_stage_fetch_ctrl.sv
module tb_if_stage_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_r;
  logic        load_use_stall;
  logic        branch_hazard_stall;
  logic        branch_taken_IF_flush;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] if_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_fetches, stat_flushes, stat_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  if_stage_fetch_ctrl_if bus ();

  // Memory model: returns the fetch address as the instruction word.
  assign bus.imem_rdata = bus.imem_addr;
  assign bus.imem_ready = ready_r;

  if_stage_fetch_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
`ifdef BRANCH_STATS_EN
    .stat_fetches          (stat_fetches),
    .stat_flushes          (stat_flushes),
    .stat_stall_cycles     (stat_stall_cycles),
`endif
    .imem                  (bus),
    .load_use_stall        (load_use_stall),
    .branch_hazard_stall   (branch_hazard_stall),
    .branch_taken_IF_flush (branch_taken_IF_flush),
    .branch_target         (branch_target),
    .jump_en               (jump_en),
    .jump_target           (jump_target),
    .if_pc                 (if_pc),
    .ifid_instr            (ifid_instr),
    .ifid_pc_plus4         (ifid_pc_plus4),
    .ifid_valid            (ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line per transaction: checks pc and all IF/ID fields.
  task automatic expect_state(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid);
    $display("%s: pc=0x%08h instr=0x%08h pc4=0x%08h valid=%0d",
             tag, if_pc, ifid_instr, ifid_pc_plus4, ifid_valid);
    check({tag, ".pc"},    if_pc,         pc);
    check({tag, ".instr"}, ifid_instr,    instr);
    check({tag, ".pc4"},   ifid_pc_plus4, pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  initial begin
    rst_n = 1'b0; ready_r = 1'b1;
    load_use_stall = 1'b0; branch_hazard_stall = 1'b0;
    branch_taken_IF_flush = 1'b0; branch_target = 32'd0;
    jump_en = 1'b0; jump_target = 32'd0;

    step(); step();
    expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.req", {31'd0, bus.imem_req}, 32'd0);

    rst_n = 1'b1;
    #1;
    check("run.req", {31'd0, bus.imem_req}, 32'd1);

    // Sequential fetch, zero-wait memory
    step(); expect_state("seq0", 32'h04, 32'h00, 32'h04, 1'b1);
    step(); expect_state("seq1", 32'h08, 32'h04, 32'h08, 1'b1);
    step(); expect_state("seq2", 32'h0C, 32'h08, 32'h0C, 1'b1);
    step(); expect_state("seq3", 32'h10, 32'h0C, 32'h10, 1'b1);

    // Taken branch at pc=0x10 -> one bubble
    branch_taken_IF_flush = 1'b1; branch_target = 32'h40;
    step(); expect_state("flush", 32'h40, 32'h0, 32'h10, 1'b0);
    branch_taken_IF_flush = 1'b0;
    step(); expect_state("flush+1", 32'h44, 32'h40, 32'h44, 1'b1);

    // Flush held off by the operand-hazard stall
    branch_taken_IF_flush = 1'b1; branch_hazard_stall = 1'b1; branch_target = 32'h100;
    step(); expect_state("bhs0", 32'h44, 32'h40, 32'h44, 1'b1);
    step(); expect_state("bhs1", 32'h44, 32'h40, 32'h44, 1'b1);
    branch_hazard_stall = 1'b0;
    step(); expect_state("bhs_flush", 32'h100, 32'h0, 32'h44, 1'b0);
    branch_taken_IF_flush = 1'b0;
    step(); expect_state("bhs_after", 32'h104, 32'h100, 32'h104, 1'b1);

    // Jump to 0x20, then a 3-cycle wait with a jump during the 2nd wait cycle
    jump_en = 1'b1; jump_target = 32'h20;
    step(); expect_state("jmp20", 32'h20, 32'h0, 32'h104, 1'b0);
    jump_en = 1'b0; ready_r = 1'b0;
    step(); expect_state("wait1", 32'h20, 32'h0, 32'h104, 1'b0);
    check("wait1.addr", bus.imem_addr, 32'h20);
    jump_en = 1'b1; jump_target = 32'h80;
    step(); expect_state("wait2", 32'h20, 32'h0, 32'h104, 1'b0);
    check("wait2.addr", bus.imem_addr, 32'h20);
    jump_en = 1'b0;
    step(); expect_state("wait3", 32'h20, 32'h0, 32'h104, 1'b0);
    check("wait3.addr", bus.imem_addr, 32'h20);
    ready_r = 1'b1;
    step(); expect_state("pend_apply", 32'h80, 32'h0, 32'h104, 1'b0);
    step(); expect_state("pend_after", 32'h84, 32'h80, 32'h84, 1'b1);

    // Load-use stall for 2 cycles
    load_use_stall = 1'b1;
    step(); expect_state("lus0", 32'h84, 32'h80, 32'h84, 1'b1);
    step(); expect_state("lus1", 32'h84, 32'h80, 32'h84, 1'b1);
    load_use_stall = 1'b0;
    step(); expect_state("lus_after", 32'h88, 32'h84, 32'h88, 1'b1);

    // PC wrap
    jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); expect_state("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h88, 1'b0);
    jump_en = 1'b0;
    step(); expect_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

`ifdef BRANCH_STATS_EN
    check("stat_flushes", {16'd0, stat_flushes}, 32'd2);
    check("stat_stalls",  {16'd0, stat_stall_cycles}, 32'd4);
    check("stat_fetches", {16'd0, stat_fetches}, 32'd9);
`endif

    // Reset while waiting with a pending redirect: both must be abandoned
    ready_r = 1'b0; jump_en = 1'b1; jump_target = 32'h200;
    step(); expect_state("rstw_wait", 32'h0, 32'h0, 32'h0, 1'b0);
    jump_en = 1'b0; rst_n = 1'b0;
    step(); expect_state("rstw_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1; ready_r = 1'b1;
    step(); expect_state("rstw_run", 32'h04, 32'h0, 32'h04, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
